// File: rtl/jk_counter_pkg.sv
// Shared JK excitation types and helpers for the modulo counter and its cells.
package jk_counter_pkg;

    typedef struct packed {
        logic j;
        logic k;
    } jk_t;

    localparam jk_t JK_HOLD   = '{j: 1'b0, k: 1'b0};
    localparam jk_t JK_RESET  = '{j: 1'b0, k: 1'b1};
    localparam jk_t JK_SET    = '{j: 1'b1, k: 1'b0};
    localparam jk_t JK_TOGGLE = '{j: 1'b1, k: 1'b1};

    // Smallest J/K pair that moves a cell from cur_bit to next_bit.
    function automatic jk_t jk_for(input logic cur_bit, input logic next_bit);
        jk_t r;
        if (cur_bit == next_bit) r = JK_HOLD;
        else if (next_bit)       r = JK_SET;
        else                     r = JK_RESET;
        return r;
    endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control and status bundle of the JK modulo counter.
interface jk_mod_counter_if #(parameter int WIDTH = 4);

    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (output en, up_dn, load, load_val,
                    input  q, tc, wrap, load_err);

    modport slave  (input  en, up_dn, load, load_val,
                    output q, tc, wrap, load_err);

endinterface

// File: rtl/jk_mod_counter_cell.sv
// Single JK flip-flop: 00 hold, 01 clear, 10 set, 11 toggle; async active-low reset.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from JK cells; excitation logic lives here.
// Define JK_COUNTER_SATURATE_EN to hold at the terminal value instead of wrapping.
module jk_mod_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    jk_mod_counter_if.slave       bus
);

    if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
        $error("jk_mod_counter: MODULO out of range for WIDTH");
    end

    localparam logic [WIDTH-1:0] CMAX    = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0] qbits;
    jk_t              jk [WIDTH];
    logic             wrap_next;
    logic             illegal_load;
    logic             carry;
    logic             wrap_r;
    logic             err_r;

    wire load_ok = ({1'b0, bus.load_val} < MOD_EXT);
    wire at_max  = (qbits == CMAX);
    wire at_zero = (qbits == '0);

    // Load wins over counting; an out-of-range load freezes the count for that edge.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) jk[i] = JK_HOLD;
        wrap_next    = 1'b0;
        illegal_load = 1'b0;
        carry        = 1'b1;
        if (bus.load) begin
            if (load_ok) begin
                for (int i = 0; i < WIDTH; i++)
                    jk[i] = bus.load_val[i] ? JK_SET : JK_RESET;
            end else begin
                illegal_load = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (at_max) begin
`ifdef JK_COUNTER_SATURATE_EN
                    wrap_next = 1'b0;
`else
                    for (int i = 0; i < WIDTH; i++) jk[i] = jk_for(qbits[i], 1'b0);
                    wrap_next = 1'b1;
`endif
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        jk[i] = carry ? JK_TOGGLE : JK_HOLD;
                        carry = carry & qbits[i];
                    end
                end
            end else begin
                if (at_zero) begin
`ifdef JK_COUNTER_SATURATE_EN
                    wrap_next = 1'b0;
`else
                    for (int i = 0; i < WIDTH; i++) jk[i] = CMAX[i] ? JK_SET : JK_RESET;
                    wrap_next = 1'b1;
`endif
                end else begin
                    // A bit toggles on the way down once every lower bit is zero (borrow chain).
                    for (int i = 0; i < WIDTH; i++) begin
                        jk[i] = carry ? JK_TOGGLE : JK_HOLD;
                        carry = carry & ~qbits[i];
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (jk[i].j),
            .k   (jk[i].k),
            .q   (qbits[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            wrap_r <= wrap_next;
            if (illegal_load) err_r <= 1'b1;
        end
    end

    assign bus.q        = qbits;
    assign bus.tc       = bus.en & ((bus.up_dn & at_max) | (~bus.up_dn & at_zero));
    assign bus.wrap     = wrap_r;
    assign bus.load_err = err_r;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (WIDTH=4, MODULO=10); honours JK_COUNTER_SATURATE_EN.
module tb_jk_mod_counter;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    jk_mod_counter_if #(.WIDTH(4)) bus ();

    jk_mod_counter #(.WIDTH(4), .MODULO(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] up_q    [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic       up_wrap [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [3:0] dn_q    [4]  = '{4'd1, 4'd0, 4'd9, 4'd8};
    logic       dn_tc   [4]  = '{0, 1, 0, 0};
    logic       dn_wrap [4]  = '{0, 0, 1, 0};

    task automatic applyStimulus(input logic en, input logic up_dn, input logic load, input logic [3:0] val);
        bus.en       = en;
        bus.up_dn    = up_dn;
        bus.load     = load;
        bus.load_val = val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        #12;
        checkOutput("reset_q", bus.q, 4'd0);
        checkOutput("reset_wrap", {3'b0, bus.wrap}, 4'd0);
        checkOutput("reset_err", {3'b0, bus.load_err}, 4'd0);
        rst = 1'b1;

        // Count to 7, then pull reset between edges.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        repeat (7) tick();
        checkOutput("pre_reset_q", bus.q, 4'd7);
        #3 rst = 1'b0;
        #1;
        checkOutput("async_reset_q", bus.q, 4'd0);
        checkOutput("async_reset_wrap", {3'b0, bus.wrap}, 4'd0);
        #1 rst = 1'b1;
        tick();
        checkOutput("post_release_q", bus.q, 4'd1);

`ifdef JK_COUNTER_SATURATE_EN
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd8);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("sat_up_q", bus.q, 4'd9);
            checkOutput("sat_up_wrap", {3'b0, bus.wrap}, 4'd0);
            checkOutput("sat_up_tc", {3'b0, bus.tc}, 4'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("sat_dn_q", bus.q, 4'd0);
            checkOutput("sat_dn_wrap", {3'b0, bus.wrap}, 4'd0);
        end
`else
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        checkOutput("load0_q", bus.q, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput("up_q", bus.q, up_q[i]);
            checkOutput("up_wrap", {3'b0, bus.wrap}, {3'b0, up_wrap[i]});
            checkOutput("up_tc", {3'b0, bus.tc}, {3'b0, (up_q[i] == 4'd9)});
        end

        applyStimulus(1'b0, 1'b1, 1'b1, 4'd2);
        tick();
        checkOutput("load2_q", bus.q, 4'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("dn_q", bus.q, dn_q[i]);
            checkOutput("dn_tc", {3'b0, bus.tc}, {3'b0, dn_tc[i]});
            checkOutput("dn_wrap", {3'b0, bus.wrap}, {3'b0, dn_wrap[i]});
        end
`endif

        // Load beats enable, then an out-of-range load is rejected and remembered.
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd5);
        tick();
        checkOutput("load5_q", bus.q, 4'd5);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd3);
        tick();
        checkOutput("load_prio_q", bus.q, 4'd3);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd12);
        tick();
        checkOutput("illegal_hold_q", bus.q, 4'd3);
        checkOutput("illegal_err", {3'b0, bus.load_err}, 4'd1);
        checkOutput("illegal_wrap", {3'b0, bus.wrap}, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        checkOutput("after_illegal_q", bus.q, 4'd4);
        checkOutput("err_sticky", {3'b0, bus.load_err}, 4'd1);

        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold_q", bus.q, 4'd4);
            checkOutput("hold_tc", {3'b0, bus.tc}, 4'd0);
        end

        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        checkOutput("flip1_q", bus.q, 4'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput("flip2_q", bus.q, 4'd4);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        checkOutput("flip3_q", bus.q, 4'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput("flip4_q", bus.q, 4'd4);
        checkOutput("err_still_set", {3'b0, bus.load_err}, 4'd1);

        #2 rst = 1'b0;
        #1;
        checkOutput("reset_clears_err", {3'b0, bus.load_err}, 4'd0);
        checkOutput("reset_clears_q", bus.q, 4'd0);
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
